// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: control-bit indices, MEM stage
// FSM states and the MEM/WB pipeline register layout.
package mips_pkg;

    // Bit positions inside the M control group {Branch, MemRead, MemWrite}
    localparam int M_BRANCH = 2;
    localparam int M_READ   = 1;
    localparam int M_WRITE  = 0;

    // Bit positions inside the WB control group {RegWrite, MemtoReg}
    localparam int WB_REGWRITE = 1;
    localparam int WB_MEMTOREG = 0;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

    typedef struct packed {
        logic [1:0]  wb;
        logic [31:0] rdata;
        logic [31:0] alu;
        logic [4:0]  wreg;
    } mem_wb_t;

    // A bubble carries no write-back and zero payload
    localparam mem_wb_t MEM_WB_BUBBLE = '0;

    // Data memory is word addressed; drop the byte offset
    function automatic logic [31:0] word_align(input logic [31:0] byte_addr);
        return {byte_addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/ready port.
// Handshake: the stage raises req with we/addr/wdata and keeps all four
// stable until the memory asserts ready for one cycle; rdata is only valid
// in that ready cycle. ready is ignored while req is low.
interface mem_stage_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;

    modport master (
        output req, we, addr, wdata,
        input  rdata, ready
    );

    modport slave (
        input  req, we, addr, wdata,
        output rdata, ready
    );
endinterface

// File: rtl/mem_stage_mem_wb.sv
// MEM/WB pipeline register. Loads every cycle; the MEM stage FSM decides
// whether the loaded value is a real instruction or a bubble.
module mem_wb
    import mips_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  mem_wb_t d_i,
    output mem_wb_t q_o
);

    mem_wb_t q_q;

    // Unconditional load with synchronous clear
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= MEM_WB_BUBBLE;
        end else begin
            q_q <= d_i;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/mem_stage.sv
// MEM stage: branch resolution, data-memory transaction with stall and
// timeout, and the MEM/WB pipeline register that feeds write-back.
module mem_stage
    import mips_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  ex_mem_wb,
    input  logic [2:0]  ex_mem_m,
    input  logic [31:0] ex_mem_alu,
    input  logic [31:0] ex_mem_add,
    input  logic [31:0] ex_mem_rd2,
    input  logic [4:0]  ex_mem_wreg,
    input  logic        ex_mem_zero,
    output logic        pc_src,
    output logic [31:0] branch_target,
    output logic        stall,
    output logic        mem_err,
    output logic [1:0]  mem_wb_wb,
    output logic [31:0] mem_wb_rdata,
    output logic [31:0] mem_wb_alu,
    output logic [4:0]  mem_wb_wreg,
    output mem_state_t  state_dbg,
    mem_stage_if.master dmem
);

    // Counter is at least 8 bits and wide enough to hold TIMEOUT itself
    localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    mem_state_t  state_q;
    logic        req_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        err_q;
    logic [CW-1:0] cnt_q;

    logic    mem_read;
    logic    mem_write;
    logic    access;
    logic    illegal;
    logic    misaligned;
    logic    start_access;
    logic    timeout_hit;
    mem_wb_t mem_wb_d;
    mem_wb_t mem_wb_q;

    assign mem_read     = ex_mem_m[M_READ];
    assign mem_write    = ex_mem_m[M_WRITE];
    assign access       = mem_read ^ mem_write;
    assign illegal      = mem_read & mem_write;
    assign misaligned   = access & (ex_mem_alu[1:0] != 2'b00);
    assign start_access = access & ~misaligned;
    assign timeout_hit  = (TIMEOUT > 0) && (cnt_q == CW'(TIMEOUT));

    // Branch resolution is independent of the memory side and of stall
    assign pc_src        = ex_mem_m[M_BRANCH] & ex_mem_zero;
    assign branch_target = ex_mem_add;

    // Stall decision and MEM/WB next value for the current state
    always_comb begin
        stall    = 1'b0;
        mem_wb_d = MEM_WB_BUBBLE;
        case (state_q)
            IDLE: begin
                if (start_access) begin
                    stall = 1'b1;
                end else if (!(illegal || misaligned)) begin
                    mem_wb_d = '{wb: ex_mem_wb, rdata: 32'h0,
                                 alu: ex_mem_alu, wreg: ex_mem_wreg};
                end
            end
            WAIT: begin
                if (dmem.ready) begin
                    mem_wb_d = '{wb: ex_mem_wb,
                                 rdata: mem_read ? dmem.rdata : 32'h0,
                                 alu: ex_mem_alu, wreg: ex_mem_wreg};
                end else if (!timeout_hit) begin
                    stall = 1'b1;
                end
            end
            default: begin
                stall = 1'b0;
            end
        endcase
    end

    // FSM with registered request fields, error pulse and wait counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_access) begin
                        req_q   <= 1'b1;
                        we_q    <= mem_write;
                        addr_q  <= word_align(ex_mem_alu);
                        wdata_q <= ex_mem_rd2;
                        cnt_q   <= '0;
                        state_q <= WAIT;
                    end else if (illegal || misaligned) begin
                        err_q <= 1'b1;
                    end
                end
                WAIT: begin
                    if (dmem.ready) begin
                        req_q   <= 1'b0;
                        state_q <= IDLE;
                    end else if (timeout_hit) begin
                        req_q   <= 1'b0;
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                    end else if (cnt_q != {CW{1'b1}}) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    mem_wb u_mem_wb (
        .clk (clk),
        .rst (rst),
        .d_i (mem_wb_d),
        .q_o (mem_wb_q)
    );

    assign dmem.req   = req_q;
    assign dmem.we    = we_q;
    assign dmem.addr  = addr_q;
    assign dmem.wdata = wdata_q;

    assign mem_err      = err_q;
    assign mem_wb_wb    = mem_wb_q.wb;
    assign mem_wb_rdata = mem_wb_q.rdata;
    assign mem_wb_alu   = mem_wb_q.alu;
    assign mem_wb_wreg  = mem_wb_q.wreg;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: vector table for single-cycle behaviour, hand-written
// sequences for load/store waits, timeout and reset mid-transaction.
module tb_mem_stage;
    import mips_pkg::*;

    logic        clk;
    logic        rst;
    logic [1:0]  ex_mem_wb;
    logic [2:0]  ex_mem_m;
    logic [31:0] ex_mem_alu;
    logic [31:0] ex_mem_add;
    logic [31:0] ex_mem_rd2;
    logic [4:0]  ex_mem_wreg;
    logic        ex_mem_zero;
    logic        pc_src;
    logic [31:0] branch_target;
    logic        stall;
    logic        mem_err;
    logic [1:0]  mem_wb_wb;
    logic [31:0] mem_wb_rdata;
    logic [31:0] mem_wb_alu;
    logic [4:0]  mem_wb_wreg;
    mem_state_t  state_dbg;

    mem_stage_if dmem_bus ();

    int tests_run = 0;
    int tests_failed = 0;

    mem_stage #(.TIMEOUT(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .ex_mem_wb     (ex_mem_wb),
        .ex_mem_m      (ex_mem_m),
        .ex_mem_alu    (ex_mem_alu),
        .ex_mem_add    (ex_mem_add),
        .ex_mem_rd2    (ex_mem_rd2),
        .ex_mem_wreg   (ex_mem_wreg),
        .ex_mem_zero   (ex_mem_zero),
        .pc_src        (pc_src),
        .branch_target (branch_target),
        .stall         (stall),
        .mem_err       (mem_err),
        .mem_wb_wb     (mem_wb_wb),
        .mem_wb_rdata  (mem_wb_rdata),
        .mem_wb_alu    (mem_wb_alu),
        .mem_wb_wreg   (mem_wb_wreg),
        .state_dbg     (state_dbg),
        .dmem          (dmem_bus)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  wb;
        logic [2:0]  m;
        logic [31:0] alu;
        logic [31:0] add;
        logic [31:0] rd2;
        logic [4:0]  wreg;
        logic        zero;
        logic        ready;
        logic [31:0] rdata;
        logic        exp_pc;
        logic        exp_err;
        logic [1:0]  exp_wb;
        logic [31:0] exp_alu;
        logic [4:0]  exp_wreg;
    } vec_t;

    localparam int NV = 7;
    vec_t vec [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Advance one clock and settle just after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] wb, input logic [2:0] m, input logic [31:0] alu,
                         input logic [31:0] add, input logic [31:0] rd2, input logic [4:0] wreg,
                         input logic zero);
        ex_mem_wb   = wb;
        ex_mem_m    = m;
        ex_mem_alu  = alu;
        ex_mem_add  = add;
        ex_mem_rd2  = rd2;
        ex_mem_wreg = wreg;
        ex_mem_zero = zero;
    endtask

    task automatic drive_nop();
        drive(2'b00, 3'b000, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
        dmem_bus.ready = 1'b0;
        dmem_bus.rdata = 32'h0;
    endtask

    initial begin
        // Reset
        rst = 1'b1;
        drive_nop();
        step();
        step();
        rst = 1'b0;
        #1;
        check("rst_state", 32'(state_dbg), 32'(IDLE));
        check("rst_req", 32'(dmem_bus.req), 32'h0);
        check("rst_addr", dmem_bus.addr, 32'h0);
        check("rst_err", 32'(mem_err), 32'h0);
        check("rst_mwb_wb", 32'(mem_wb_wb), 32'h0);
        check("rst_mwb_alu", mem_wb_alu, 32'h0);
        check("rst_stall", 32'(stall), 32'h0);

        // Single-cycle vectors, all started from IDLE
        //          wb     m       alu           add       rd2    wreg  z     rdy   rdata     pc    err   ewb    ealu          ewreg
        vec[0] = '{2'b10, 3'b000, 32'h1234,     32'h0,    32'h0, 5'd5, 1'b0, 1'b0, 32'h0,    1'b0, 1'b0, 2'b10, 32'h1234,     5'd5};
        vec[1] = '{2'b00, 3'b100, 32'h0,        32'h40,   32'h0, 5'd0, 1'b1, 1'b0, 32'h0,    1'b1, 1'b0, 2'b00, 32'h0,        5'd0};
        vec[2] = '{2'b00, 3'b100, 32'h5,        32'h80,   32'h0, 5'd3, 1'b0, 1'b0, 32'h0,    1'b0, 1'b0, 2'b00, 32'h5,        5'd3};
        vec[3] = '{2'b11, 3'b010, 32'h102,      32'h0,    32'h0, 5'd8, 1'b0, 1'b0, 32'h0,    1'b0, 1'b1, 2'b00, 32'h0,        5'd0};
        vec[4] = '{2'b00, 3'b001, 32'h203,      32'h0,    32'h9, 5'd0, 1'b0, 1'b0, 32'h0,    1'b0, 1'b1, 2'b00, 32'h0,        5'd0};
        vec[5] = '{2'b11, 3'b011, 32'h100,      32'h0,    32'h0, 5'd4, 1'b0, 1'b0, 32'h0,    1'b0, 1'b1, 2'b00, 32'h0,        5'd0};
        vec[6] = '{2'b10, 3'b000, 32'hFFFFFFFC, 32'h10,   32'h0, 5'd31,1'b1, 1'b1, 32'h55,   1'b0, 1'b0, 2'b10, 32'hFFFFFFFC, 5'd31};

        for (int i = 0; i < NV; i++) begin
            drive(vec[i].wb, vec[i].m, vec[i].alu, vec[i].add, vec[i].rd2, vec[i].wreg, vec[i].zero);
            dmem_bus.ready = vec[i].ready;
            dmem_bus.rdata = vec[i].rdata;
            #1;
            check($sformatf("v%0d_pc_src", i), 32'(pc_src), 32'(vec[i].exp_pc));
            check($sformatf("v%0d_target", i), branch_target, vec[i].add);
            check($sformatf("v%0d_stall", i), 32'(stall), 32'h0);
            step();
            check($sformatf("v%0d_err", i), 32'(mem_err), 32'(vec[i].exp_err));
            check($sformatf("v%0d_req", i), 32'(dmem_bus.req), 32'h0);
            check($sformatf("v%0d_mwb_wb", i), 32'(mem_wb_wb), 32'(vec[i].exp_wb));
            check($sformatf("v%0d_mwb_alu", i), mem_wb_alu, vec[i].exp_alu);
            check($sformatf("v%0d_mwb_wreg", i), 32'(mem_wb_wreg), 32'(vec[i].exp_wreg));
            check($sformatf("v%0d_mwb_rdata", i), mem_wb_rdata, 32'h0);
        end
        drive_nop();
        step();
        check("err_clears", 32'(mem_err), 32'h0);

        // Load with ready in the third request cycle
        begin
            int stall_cnt;
            int req_cnt;
            stall_cnt = 0;
            req_cnt = 0;
            drive(2'b11, 3'b010, 32'h100, 32'h0, 32'h0, 5'd7, 1'b0);
            #1;
            check("ld_idle_stall", 32'(stall), 32'h1);
            if (stall) stall_cnt++;
            step();
            for (int c = 0; c < 3; c++) begin
                if (c == 2) begin
                    dmem_bus.ready = 1'b1;
                    dmem_bus.rdata = 32'hDEADBEEF;
                end
                #1;
                if (dmem_bus.req) req_cnt++;
                if (stall) stall_cnt++;
                check("ld_addr", dmem_bus.addr, 32'h100);
                check("ld_we", 32'(dmem_bus.we), 32'h0);
                check("ld_wait_bubble", 32'(mem_wb_wb), 32'h0);
                step();
            end
            check("ld_stall_cycles", 32'(stall_cnt), 32'd3);
            check("ld_req_cycles", 32'(req_cnt), 32'd3);
            check("ld_rdata", mem_wb_rdata, 32'hDEADBEEF);
            check("ld_mwb_wb", 32'(mem_wb_wb), 32'h3);
            check("ld_mwb_alu", mem_wb_alu, 32'h100);
            check("ld_mwb_wreg", 32'(mem_wb_wreg), 32'd7);
            check("ld_req_drop", 32'(dmem_bus.req), 32'h0);
            drive_nop();
            step();
            check("ld_no_reissue", 32'(dmem_bus.req), 32'h0);
        end

        // Store with ready in the first request cycle
        drive(2'b01, 3'b001, 32'h204, 32'h0, 32'hCAFEF00D, 5'd2, 1'b0);
        #1;
        check("st_idle_stall", 32'(stall), 32'h1);
        step();
        check("st_req", 32'(dmem_bus.req), 32'h1);
        check("st_we", 32'(dmem_bus.we), 32'h1);
        check("st_addr", dmem_bus.addr, 32'h204);
        check("st_wdata", dmem_bus.wdata, 32'hCAFEF00D);
        dmem_bus.ready = 1'b1;
        #1;
        check("st_ready_stall", 32'(stall), 32'h0);
        step();
        check("st_mwb_wb", 32'(mem_wb_wb), 32'h1);
        check("st_mwb_rdata", mem_wb_rdata, 32'h0);
        check("st_mwb_alu", mem_wb_alu, 32'h204);
        check("st_req_drop", 32'(dmem_bus.req), 32'h0);
        drive_nop();
        step();

        // Timeout: ready never comes, TIMEOUT = 4
        drive(2'b11, 3'b010, 32'h300, 32'h0, 32'h0, 5'd9, 1'b0);
        step();
        for (int c = 0; c < 4; c++) begin
            check($sformatf("to_stall_%0d", c), 32'(stall), 32'h1);
            check($sformatf("to_err_%0d", c), 32'(mem_err), 32'h0);
            step();
        end
        check("to_release", 32'(stall), 32'h0);
        check("to_req_held", 32'(dmem_bus.req), 32'h1);
        step();
        drive_nop();
        check("to_err", 32'(mem_err), 32'h1);
        check("to_req_drop", 32'(dmem_bus.req), 32'h0);
        check("to_bubble", 32'(mem_wb_wb), 32'h0);
        check("to_state", 32'(state_dbg), 32'(IDLE));
        step();
        check("to_err_pulse", 32'(mem_err), 32'h0);

        // Reset while waiting on memory
        drive(2'b10, 3'b000, 32'h77, 32'h0, 32'h0, 5'd6, 1'b0);
        step();
        check("pre_rst_alu", mem_wb_alu, 32'h77);
        drive(2'b11, 3'b010, 32'h400, 32'h0, 32'h0, 5'd6, 1'b0);
        step();
        check("pre_rst_req", 32'(dmem_bus.req), 32'h1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        drive_nop();
        check("wrst_req", 32'(dmem_bus.req), 32'h0);
        check("wrst_state", 32'(state_dbg), 32'(IDLE));
        check("wrst_mwb_wb", 32'(mem_wb_wb), 32'h0);
        check("wrst_mwb_alu", mem_wb_alu, 32'h0);
        check("wrst_mwb_rdata", mem_wb_rdata, 32'h0);
        check("wrst_mwb_wreg", 32'(mem_wb_wreg), 32'h0);
        check("wrst_err", 32'(mem_err), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
